// File: rtl/rapid_pkg.sv
// Shared types and constants for the rapid core pipeline.
// Holds the fetch-to-decode queue entry layout and its top-level depth.
package rapid_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned IF_ID_DEPTH = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instruction;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_queue.sv
// Decoupling queue between instruction fetch and decode.
// Fetch is back-pressured from registered occupancy only; flush discards everything.
module if_id_queue #(
  parameter int unsigned  XLEN  = rapid_pkg::XLEN,
  parameter int unsigned  DEPTH = rapid_pkg::IF_ID_DEPTH,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_if_done,
  input  logic [XLEN-1:0] i_if_pc,
  input  logic [XLEN-1:0] i_if_instruction,
  output logic            o_if_ready,
  output logic            o_id_valid,
  output logic [XLEN-1:0] o_id_pc,
  output logic [XLEN-1:0] o_id_instruction,
  output logic            o_id_misaligned,
  input  logic            i_id_ready,
  input  logic            i_flush,
  output logic [CntW-1:0] o_count
);

  import rapid_pkg::*;

  if_id_entry_t    mem [DEPTH];
  if_id_entry_t    head;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  // Ready depends on registered count only, never on i_id_ready.
  assign o_if_ready = (count_q != CntW'(DEPTH));
  assign o_id_valid = (count_q != '0);

  assign push = i_if_done && o_if_ready && !i_flush;
  assign pop  = o_id_valid && i_id_ready && !i_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_q] <= '{pc: i_if_pc, instruction: i_if_instruction};
    end
  end

  always_comb begin
    head             = mem[rd_ptr_q];
    o_id_pc          = '0;
    o_id_instruction = '0;
    if (o_id_valid) begin
      o_id_pc          = head.pc;
      o_id_instruction = head.instruction;
    end
  end

  assign o_id_misaligned = o_id_valid && (o_id_pc[1:0] != 2'b00);
  assign o_count         = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios with literal expectations plus
// randomized fetch/decode traffic compared every cycle against a queue model.
module tb_if_id_queue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  logic            clk;
  logic            rst_n;
  logic            done;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr;
  logic            if_ready;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_instr;
  logic            id_mis;
  logic            id_ready;
  logic            flush;
  logic [CntW-1:0] count;

  int checks = 0;
  int errors = 0;

  if_id_queue #(
    .XLEN (XLEN),
    .DEPTH(DEPTH)
  ) dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_if_done       (done),
    .i_if_pc         (pc),
    .i_if_instruction(instr),
    .o_if_ready      (if_ready),
    .o_id_valid      (id_valid),
    .o_id_pc         (id_pc),
    .o_id_instruction(id_instr),
    .o_id_misaligned (id_mis),
    .i_id_ready      (id_ready),
    .i_flush         (flush),
    .o_count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of {pc, instr}, updated by the rules
  // "flush empties, otherwise pop the head if decode takes it, append if room".
  logic [63:0] model_q[$];
  bit          acc_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
      acc_m = 1'b0;
    end else begin
      bit room, have;
      room  = (model_q.size() < DEPTH);
      have  = (model_q.size() > 0);
      acc_m = done && room && !flush;
      if (flush) begin
        model_q.delete();
      end else begin
        if (have && id_ready) void'(model_q.pop_front());
        if (acc_m) model_q.push_back({pc, instr});
      end
    end
  end

  // Outputs never depend combinationally on inputs, so the falling edge is a clean sample point.
  always @(negedge clk) begin
    logic [XLEN-1:0] e_pc, e_in;
    bit              e_valid;
    e_valid = (model_q.size() != 0);
    e_pc    = e_valid ? model_q[0][63:32] : '0;
    e_in    = e_valid ? model_q[0][31:0] : '0;
    check("m_count", 64'(count), 64'(model_q.size()));
    check("m_valid", 64'(id_valid), 64'(e_valid));
    check("m_ready", 64'(if_ready), 64'(model_q.size() != DEPTH));
    check("m_pc", 64'(id_pc), 64'(e_pc));
    check("m_instr", 64'(id_instr), 64'(e_in));
    check("m_mis", 64'(id_mis), 64'(e_valid && (e_pc[1:0] != 2'b00)));
  end

  // Apply one cycle of inputs just after the falling edge.
  task automatic drive(input logic d, input logic [XLEN-1:0] p, input logic [XLEN-1:0] i,
                       input logic r, input logic f);
    @(negedge clk);
    #1;
    done     = d;
    pc       = p;
    instr    = i;
    id_ready = r;
    flush    = f;
  endtask

  // Sample just after the edge that consumes the inputs applied by drive.
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_two(input logic [XLEN-1:0] base);
    drive(1'b1, base, 32'hA000_0000 | base, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b1, base + 32'h4, 32'hA000_0000 | (base + 32'h4), 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    done = 1'b0; pc = '0; instr = '0; id_ready = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    settle();
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(id_valid), 64'd0);
    check("rst_ready", 64'(if_ready), 64'd1);

    // In-order delivery with decode stalled, then drained.
    drive(1'b1, 32'h0, 32'h0000_0013, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b1, 32'h4, 32'h00A0_0093, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    settle();
    check("io_count", 64'(count), 64'd2);
    check("io_ready", 64'(if_ready), 64'd0);
    check("io_pc0", 64'(id_pc), 64'h0);
    check("io_in0", 64'(id_instr), 64'h13);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    settle();
    check("io_pc1", 64'(id_pc), 64'h4);
    check("io_in1", 64'(id_instr), 64'h00A0_0093);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    settle();
    check("io_empty", 64'(id_valid), 64'd0);

    // Full back-pressure: fetch holds pc=0x8 until accepted.
    fill_two(32'h40);
    drive(1'b1, 32'h8, 32'h0000_8888, 1'b0, 1'b0);
    drive(1'b1, 32'h8, 32'h0000_8888, 1'b0, 1'b0);
    settle();
    check("bp_hold", 64'(count), 64'd2);
    drive(1'b1, 32'h8, 32'h0000_8888, 1'b1, 1'b0);
    settle();
    check("bp_pop", 64'(count), 64'd1);
    check("bp_rdy", 64'(if_ready), 64'd1);
    drive(1'b1, 32'h8, 32'h0000_8888, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    settle();
    check("bp_once", 64'(count), 64'd2);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    settle();
    check("bp_pc8", 64'(id_pc), 64'h8);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    settle();
    check("bp_drain", 64'(count), 64'd0);

    // Simultaneous push/pop at count=1, then eight more pairs across pointer wrap.
    drive(1'b1, 32'h20, 32'h2020, 1'b0, 1'b0);
    drive(1'b1, 32'hC, 32'h0C0C, 1'b1, 1'b0);
    settle();
    check("sim_count", 64'(count), 64'd1);
    check("sim_head", 64'(id_pc), 64'hC);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'h200 + 32'(4 * k), 32'h5000 + 32'(k), 1'b1, 1'b0);
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      settle();
      check("wrap_head", 64'(id_pc), 64'(32'h200 + 32'(4 * k)));
      check("wrap_count", 64'(count), 64'd1);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush wins over a simultaneous push and pop.
    fill_two(32'h60);
    drive(1'b1, 32'h100, 32'h0100_0100, 1'b1, 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    settle();
    check("fl_count", 64'(count), 64'd0);
    check("fl_valid", 64'(id_valid), 64'd0);

    // Misaligned flag follows the head PC.
    drive(1'b1, 32'h6, 32'h0666, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    settle();
    check("mis_set", 64'(id_mis), 64'd1);
    drive(1'b1, 32'h8, 32'h0888, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    settle();
    check("mis_clr", 64'(id_mis), 64'd0);
    check("mis_pc", 64'(id_pc), 64'h8);
    drive(1'b0, '0, '0, 1'b1, 1'b0);

    // Asynchronous reset while full, sampled between edges.
    fill_two(32'h80);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_count", 64'(count), 64'd0);
    check("ar_valid", 64'(id_valid), 64'd0);
    check("ar_ready", 64'(if_ready), 64'd1);
    check("ar_pc", 64'(id_pc), 64'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic: fetch keeps an offer up until accepted, drops it the
    // cycle after acceptance or a redirect, then may offer a new one.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      #1;
      if (done && (acc_m || flush)) begin
        done = 1'b0;
      end else if (!done && ($urandom_range(0, 3) != 0)) begin
        done  = 1'b1;
        pc    = $urandom;
        instr = $urandom;
      end
      id_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 19) == 0);
    end

    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Decoupling buffer between instruction_fetch and the decode stage.
- Captures each {pc, instruction} pair that fetch completes, and drives fetch's i_pipeline_ready as back-pressure.
- Presents entries in order to decode over a valid/ready handshake.
- Supports a single-cycle flush on branch redirect, so wrong-path instructions never reach decode.

Parameters:
- XLEN, 32, data/address width.
- DEPTH, 2, number of entries; power of two, at least 2.

Ports:
- i_clk  input  1  clock.
- i_reset_n  input  1  asynchronous active-low reset.
- i_if_done  input  1  fetch has a completed instruction (fetch o_done).
- i_if_pc  input  XLEN  PC of the offered instruction.
- i_if_instruction  input  XLEN  offered instruction word.
- o_if_ready  output  1  queue can accept; drives fetch i_pipeline_ready.
- o_id_valid  output  1  head entry valid for decode.
- o_id_pc  output  XLEN  head entry PC.
- o_id_instruction  output  XLEN  head entry instruction.
- o_id_misaligned  output  1  head PC bits [1:0] nonzero.
- i_id_ready  input  1  decode consumes head this cycle.
- i_flush  input  1  discard all entries (branch redirect).
- o_count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_reset_n is asynchronous, active-low.
- Reset values:
  - o_count=0, o_id_valid=0, o_if_ready=1.
  - o_id_pc=0, o_id_instruction=0, o_id_misaligned=0.
  - Read and write pointers = 0; storage contents don't-care.
- Storage: circular buffer of DEPTH entries of if_id_entry_t. Pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is a separate counter.
- Push: fires when i_if_done && o_if_ready && !i_flush.
  - Write {i_if_pc, i_if_instruction} at wr_ptr, then wr_ptr+1.
- Pop: fires when o_id_valid && i_id_ready && !i_flush.
  - rd_ptr+1.
- Count update:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
- Ready: o_if_ready = (count != DEPTH). It is combinational from registered count only, with no path from i_id_ready, which keeps fetch's combinational loop short.
  - A push/pop pair when full is therefore not possible; when not full it is legal.
- Outputs:
  - o_id_valid = (count != 0).
  - o_id_pc and o_id_instruction are read combinationally from storage at rd_ptr.
  - When empty, o_id_pc and o_id_instruction are driven to 0.
  - o_id_misaligned = o_id_valid && (o_id_pc[1:0] != 0).
- Latency: an entry pushed in cycle N is visible on o_id_valid in cycle N+1. There is no empty bypass.
- Flush: i_flush=1 at a clock edge sets count=0 and rd_ptr=wr_ptr=0.
  - Any simultaneous push or pop is suppressed.
  - o_id_valid=0 from the next cycle.
  - i_flush has priority over all other events.
- Fetch handshake compliance: fetch holds i_if_done high until it samples o_if_ready=1. The queue samples i_if_done exactly once per accepted instruction, and must not double-push an instruction fetch keeps asserting in WAIT after acceptance. Fetch drops o_done in the cycle after ready, which the bench must reflect.
- Decode stall: while !i_id_ready, the head entry and o_id_* are stable.
- Reset mid-operation: all entries are lost immediately (asynchronous); outputs return to their reset values with no clock edge required.
- Illegal input: pop while empty is ignored (o_id_valid=0 gates it); count never underflows or overflows.

Decomposition:
- rapid_pkg gains typedef if_id_entry_t, a packed struct {logic [XLEN-1:0] pc; logic [XLEN-1:0] instruction;} at the package XLEN.
- rapid_pkg also gains constant IF_ID_DEPTH=2 for the top-level instantiation.
- No sub-module: pointer/counter logic and storage live in if_id_queue. A generic FIFO is not warranted at this size.

Test Plan:
- Reset: release i_reset_n -> o_count=0, o_id_valid=0, o_if_ready=1. Assert reset mid-stream with count=2 -> o_count=0 immediately, with no clock edge.
- In-order: push pc=0x0000_0000 instr=0x0000_0013, then pc=0x4 instr=0x00A0_0093, with i_id_ready=0 -> o_count=2, o_if_ready=0. Raise i_id_ready -> decode sees 0x0/0x13, then 0x4/0x00A00093, then o_id_valid=0.
- Full back-pressure: count=2, fetch holds i_if_done=1 with pc=0x8 -> no push and count stays 2. One pop -> o_if_ready=1 next cycle, pc=0x8 pushed exactly once, count=2.
- Simultaneous: count=1, push pc=0xC and pop in the same cycle -> count stays 1, head becomes pc=0xC. Run 8 more push/pop pairs -> pointers wrap with no loss or reorder.
- Flush priority: count=2, i_flush=1 with i_if_done=1 (pc=0x100) and i_id_ready=1 -> next cycle count=0, o_id_valid=0, pc=0x100 not stored.
- Misaligned: push pc=0x0000_0006 -> o_id_misaligned=1. Push pc=0x8 -> o_id_misaligned=0.
